icache_direct_mapped: RTL

//  Direct-mapped, one-word-per-frame instruction cache between the pipelined

---
 rtl/icache_direct_mapped.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/icache_direct_mapped.sv
// ---------------------------------------------------------------------------
// icache_direct_mapped
//
// Direct-mapped instruction cache with one 32-bit word per frame. It sits
// between the fetch stage and the memory arbiter. A hit returns the word in
// the same cycle. A miss records the word address, moves to FILL, fetches
// the word from memory, installs it, and then returns to IDLE. The fetch
// stage re-presents the address and hits on the following cycle.
//
// Ports
//   CLK, RST     clock; synchronous active-high reset
//   imemREN      fetch request from the datapath
//   imemaddr     fetch byte address; bits [1:0] are ignored
//   ihit         imemload is valid this cycle
//   imemload     instruction word, or 0 when ihit is low
//   flush        invalidates every frame at the next posedge
//   iREN/iaddr   memory read request and word address (registered)
//   iwait/iload  memory busy flag and read data
//   hit_count    number of accesses that hit (wraps at 2^32)
//   miss_count   number of misses started (wraps at 2^32)
//
// Memory handshake: iREN is the request "valid" and ~iwait is the "ready".
// A transfer occurs on a posedge where iREN=1 and iwait=0, and iload is
// captured in that cycle. Once iREN is raised, it and iaddr stay stable
// until that transfer occurs. They are then dropped in the following cycle.
// ---------------------------------------------------------------------------
module icache_direct_mapped #(
  parameter  int SETS  = 16,
  localparam int IDX_W = $clog2(SETS),
  localparam int TAG_W = 30 - IDX_W
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  input  logic        flush,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  // FSM state; this is the signal that debug probes and checkers look at.
  state_t state;

  // Frame storage. Only the valid bits are reset.
  logic [SETS-1:0]  valid_q;
  logic [TAG_W-1:0] tag_q  [SETS];
  logic [31:0]      data_q [SETS];

  // Word address of the miss that is outstanding (bits [31:2]).
  logic [29:0]      miss_word;
  logic             iren_q;
  logic [31:0]      iaddr_q;

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic [IDX_W-1:0] fill_idx;
  logic [TAG_W-1:0] fill_tag;
  logic             lookup_hit;
  logic             start_miss;
  logic             fill_done;
  logic             unused_addr_bits;

  assign idx      = imemaddr[IDX_W+1:2];
  assign tag      = imemaddr[31:IDX_W+2];
  assign fill_idx = miss_word[IDX_W-1:0];
  assign fill_tag = miss_word[29:IDX_W];

  // Byte offset within the word plays no role in a word-wide cache.
  assign unused_addr_bits = ^imemaddr[1:0];

  // While flush is high, lookups are suppressed. No hit is reported, no miss
  // is started, and nothing is counted.
  assign lookup_hit = (state == IDLE) && imemREN && !flush &&
                      valid_q[idx] && (tag_q[idx] == tag);
  assign start_miss = (state == IDLE) && imemREN && !flush && !lookup_hit;
  assign fill_done  = (state == FILL) && !iwait;

  assign ihit     = lookup_hit;
  assign imemload = lookup_hit ? data_q[idx] : 32'h0;
  assign iREN     = iren_q;
  assign iaddr    = iaddr_q;

  // Control FSM with registered memory-side outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      iren_q    <= 1'b0;
      iaddr_q   <= 32'h0;
      miss_word <= 30'h0;
    end else begin
      case (state)
        IDLE: begin
          if (start_miss) begin
            state     <= FILL;
            iren_q    <= 1'b1;
            iaddr_q   <= {imemaddr[31:2], 2'b00};
            miss_word <= imemaddr[31:2];
          end
        end
        FILL: begin
          // imemaddr is ignored here; the latched miss address drives the fill.
          if (!iwait) begin
            state   <= IDLE;
            iren_q  <= 1'b0;
            iaddr_q <= 32'h0;
          end
        end
        default: begin
          state   <= IDLE;
          iren_q  <= 1'b0;
          iaddr_q <= 32'h0;
        end
      endcase
    end
  end

  // Valid bits. Flush overrides a fill that completes in the same cycle, so
  // the frame that was just written stays invalid.
  always_ff @(posedge CLK) begin
    if (RST) begin
      valid_q <= '0;
    end else if (flush) begin
      valid_q <= '0;
    end else if (fill_done) begin
      valid_q[fill_idx] <= 1'b1;
    end
  end

  // Tag and data are written on every completed fill, even under flush.
  // This is harmless because the valid bit stays clear. A memory response
  // that arrives together with reset is dropped.
  always_ff @(posedge CLK) begin
    if (fill_done && !RST) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= iload;
    end
  end

  // Statistics counters.
  always_ff @(posedge CLK) begin
    if (RST) begin
      hit_count  <= 32'h0;
      miss_count <= 32'h0;
    end else begin
      if (lookup_hit) hit_count  <= hit_count + 32'd1;
      if (start_miss) miss_count <= miss_count + 32'd1;
    end
  end

endmodule
